// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with OSR-times oversampling, mid-bit sampling,
// false-start rejection, framing-error detection and break hold-off.
`timescale 1ns/1ps
module uart_rx_os #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 19200,
    parameter int OSR    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = CLK_HZ / (BAUD * OSR);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OSR);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [1:0]    sync_q;
    logic          rxs;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sc_q, sc_d;
    logic [2:0]    bc_q, bc_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          tick;

    // Idle-high synchronizer so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxs  = sync_q[1];
    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        sc_d    = sc_q;
        bc_d    = bc_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Holding the divider at zero pins the sample phase to the edge.
                cnt_d = '0;
                sc_d  = '0;
                if (!rxs) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (tick) begin
                    if (sc_q == SW'(OSR / 2 - 1)) begin
                        sc_d    = '0;
                        bc_d    = 3'd0;
                        state_d = rxs ? S_IDLE : S_DATA;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (tick) begin
                    if (sc_q == SW'(OSR - 1)) begin
                        sc_d          = '0;
                        shift_d[bc_q] = rxs;
                        if (bc_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bc_d = bc_q + 1'b1;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (tick) begin
                    if (sc_q == SW'(OSR - 1)) begin
                        sc_d   = '0;
                        data_d = shift_q;
                        if (rxs) begin
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end

            S_BREAK: begin
                // A line held low must go high before another frame is considered.
                cnt_d = '0;
                sc_d  = '0;
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sc_q    <= '0;
            bc_q    <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
            bc_q    <= bc_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Randomized bench for uart_rx_os: frames are built from bytes and checked
// against an expected-event queue derived from what was put on the line.
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int CLK_HZ = 3200;
    localparam int BAUD   = 100;
    localparam int OSR    = 16;
    localparam int BP     = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OSR(OSR)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed output events
    int         cyc = 0;
    logic [7:0] ev_data[$];
    bit         ev_ferr[$];
    int         ev_cyc[$];
    int         both_cnt = 0;
    int         long_cnt = 0;
    logic       valid_prev = 1'b0;
    logic       ferr_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            ev_data.push_back(data);
            ev_ferr.push_back(1'b0);
            ev_cyc.push_back(cyc);
        end else if (frame_err) begin
            ev_data.push_back(data);
            ev_ferr.push_back(1'b1);
            ev_cyc.push_back(cyc);
        end
        if (valid && frame_err) both_cnt <= both_cnt + 1;
        if ((valid && valid_prev) || (frame_err && ferr_prev)) long_cnt <= long_cnt + 1;
        valid_prev <= valid;
        ferr_prev  <= frame_err;
    end

    // Reference model: one expected event per complete frame on the line
    logic [7:0] exp_data[$];
    bit         exp_ferr[$];
    logic [7:0] exp_last = 8'h00;
    int         last_start = 0;

    task automatic expect_frame(input logic [7:0] b, input bit stop_ok);
        exp_data.push_back(b);
        exp_ferr.push_back(!stop_ok);
        exp_last = b;
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_count"}, ev_data.size(), exp_data.size());
        n = (ev_data.size() < exp_data.size()) ? ev_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, ev_data[i], exp_data[i]);
            check({tag, "_ferr"}, ev_ferr[i], exp_ferr[i]);
        end
        check({tag, "_hold"}, data, exp_last);
        ev_data.delete();
        ev_ferr.delete();
        ev_cyc.delete();
        exp_data.delete();
        exp_ferr.delete();
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives start, 8 data bits LSB first and a stop bit; leaves rxd at the stop level.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bp);
        logic [7:0] v;
        v = b;
        last_start = cyc;
        rxd = 1'b0;
        repeat (bp) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = v[i];
            if (i == 4) begin
                repeat (bp / 2) @(negedge clk);
                check("busy_mid", busy, 1);
                repeat (bp - bp / 2) @(negedge clk);
            end else begin
                repeat (bp) @(negedge clk);
            end
        end
        rxd = stop_ok;
        repeat (bp) @(negedge clk);
        $display("[TB] frame 0x%02h stop=%0d bit_clocks=%0d", b, stop_ok, bp);
    endtask

    task automatic glitch(input int len, output bit seen);
        seen = 1'b0;
        rxd = 1'b0;
        repeat (len) @(negedge clk) seen |= busy;
        rxd = 1'b1;
        repeat (40) @(negedge clk) seen |= busy;
        $display("[TB] glitch low for %0d clocks", len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         seen;
        int         t0;
        logic [7:0] b;
        bit         ok;
        int         bp;

        rxd = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", data, 8'h00);
        check("reset_valid", valid, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        idle(10);

        // Single byte with fixed edge-to-pulse latency
        send_frame(8'hA5, 1'b1, BP);
        expect_frame(8'hA5, 1'b1);
        idle(8);
        check("single_busy_after", busy, 0);
        check("single_latency", (ev_cyc.size() > 0) ? ev_cyc[0] - last_start : -1, 307);
        compare_events("single");

        // Short low pulse is a false start
        glitch(6, seen);
        check("glitch_busy_seen", seen, 1);
        check("glitch_busy_after", busy, 0);
        compare_events("glitch");

        // Back-to-back frames, no idle between stop and next start
        send_frame(8'h31, 1'b1, BP);
        send_frame(8'h00, 1'b1, BP);
        expect_frame(8'h31, 1'b1);
        expect_frame(8'h00, 1'b1);
        idle(8);
        check("b2b_spacing", (ev_cyc.size() == 2) ? ev_cyc[1] - ev_cyc[0] : -1, 320);
        compare_events("b2b");

        // Framing error followed by a long break
        send_frame(8'h55, 1'b0, BP);
        expect_frame(8'h55, 1'b0);
        repeat (5 * BP) @(negedge clk);
        check("break_busy", busy, 1);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        check("break_release", busy, 0);
        idle(BP);
        compare_events("ferr");

        // Reset during data bit 4 of 0xFF
        rxd = 1'b0;
        repeat (BP) @(negedge clk);
        rxd = 1'b1;
        repeat (4 * BP + 8) @(negedge clk);
        check("rst_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_data", data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        exp_last = 8'h00;
        $display("[TB] reset mid-frame");
        idle(5 * BP);
        compare_events("rst_quiet");
        send_frame(8'h3C, 1'b1, BP);
        expect_frame(8'h3C, 1'b1);
        idle(8);
        compare_events("rst_after");

        // Rate skew of about +/-3 percent
        send_frame(8'hC3, 1'b1, 33);
        expect_frame(8'hC3, 1'b1);
        idle(8);
        compare_events("slow");
        send_frame(8'hC3, 1'b1, 31);
        expect_frame(8'hC3, 1'b1);
        idle(8);
        compare_events("fast");

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                glitch($urandom_range(1, 10), seen);
                check("rnd_glitch_busy", busy, 0);
            end
            b  = 8'($urandom_range(0, 255));
            bp = $urandom_range(31, 33);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok, bp);
            expect_frame(b, ok);
            if (!ok) begin
                repeat ($urandom_range(1, 3) * bp) @(negedge clk);
                idle($urandom_range(5, BP));
            end else begin
                idle($urandom_range(0, 2) * bp);
            end
            compare_events("rnd");
        end
        idle(40);
        check("final_busy", busy, 0);
        check("pulse_one_cycle", long_cnt, 0);
        check("pulse_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
